// File: rtl/cache_arbiter_if.sv
// Bundle of requester handshakes and cache port signals around cache_arbiter.
// slave is the arbiter's view; master is the requesters-plus-cache view.
interface cache_arbiter_if #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
);
  logic [1:0]            wr_req;
  logic [ADDR_WIDTH-1:0] wr_addr0;
  logic [ADDR_WIDTH-1:0] wr_addr1;
  logic [DATA_WIDTH-1:0] wr_data0;
  logic [DATA_WIDTH-1:0] wr_data1;
  logic [1:0]            wr_gnt;

  logic [1:0]            rd_req;
  logic [ADDR_WIDTH-1:0] rd_addr0;
  logic [ADDR_WIDTH-1:0] rd_addr1;
  logic [1:0]            rd_gnt;
  logic [1:0]            rd_valid;
  logic [DATA_WIDTH-1:0] rd_data;

  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;
  logic [DATA_WIDTH-1:0] doutb;

  modport slave (
    input  wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    input  rd_req, rd_addr0, rd_addr1,
    input  doutb,
    output wr_gnt, rd_gnt, rd_valid, rd_data,
    output wea, addra, dina, addrb
  );

  modport master (
    output wr_req, wr_addr0, wr_addr1, wr_data0, wr_data1,
    output rd_req, rd_addr0, rd_addr1,
    output doutb,
    input  wr_gnt, rd_gnt, rd_valid, rd_data,
    input  wea, addra, dina, addrb
  );
endinterface

// File: rtl/cache_arbiter.sv
// Round-robin arbiter sharing one dual-port read-first cache between two writers and
// two readers; reads that collide with a same-cycle write are deferred until it lands.
module cache_arbiter #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned ADDR_WIDTH = 10
) (
  input logic             clk,
  input logic             rst,
  cache_arbiter_if.slave  bus
);

  logic                  wr_ptr_q, wr_ptr_d;
  logic                  rd_ptr_q, rd_ptr_d;
  logic [1:0]            rd_valid_q;
  logic [ADDR_WIDTH-1:0] addrb_q;

  logic                  wr_cand;
  logic                  rd_cand;
  logic [ADDR_WIDTH-1:0] rd_cand_addr;
  logic                  hazard;
  logic [1:0]            wr_gnt;
  logic [1:0]            rd_gnt;
  logic                  wea;
  logic [ADDR_WIDTH-1:0] addra;
  logic [DATA_WIDTH-1:0] dina;
  logic [ADDR_WIDTH-1:0] addrb;

  // Write side: pointer only matters when both requesters contend.
  always_comb begin
    wr_cand = (bus.wr_req == 2'b11) ? wr_ptr_q : bus.wr_req[1];
    wr_gnt  = 2'b00;
    if (!rst && (bus.wr_req != 2'b00)) begin
      wr_gnt = wr_cand ? 2'b10 : 2'b01;
    end
    wea   = |wr_gnt;
    addra = '0;
    dina  = '0;
    if (wr_gnt[0]) begin
      addra = bus.wr_addr0;
      dina  = bus.wr_data0;
    end else if (wr_gnt[1]) begin
      addra = bus.wr_addr1;
      dina  = bus.wr_data1;
    end
    wr_ptr_d = wea ? ~wr_cand : wr_ptr_q;
  end

  // Read side: the cache is read-first, so a read to the address being written this
  // cycle would return stale data; hold it off until the write has landed.
  always_comb begin
    rd_cand      = (bus.rd_req == 2'b11) ? rd_ptr_q : bus.rd_req[1];
    rd_cand_addr = rd_cand ? bus.rd_addr1 : bus.rd_addr0;
    hazard       = wea && (rd_cand_addr == addra);
    rd_gnt       = 2'b00;
    if (!rst && (bus.rd_req != 2'b00) && !hazard) begin
      rd_gnt = rd_cand ? 2'b10 : 2'b01;
    end
    if (rst) begin
      addrb = '0;
    end else if (bus.rd_req != 2'b00) begin
      addrb = rd_cand_addr;
    end else begin
      addrb = addrb_q;
    end
    rd_ptr_d = (|rd_gnt) ? ~rd_cand : rd_ptr_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q   <= 1'b0;
      rd_ptr_q   <= 1'b0;
      rd_valid_q <= 2'b00;
      addrb_q    <= '0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      rd_valid_q <= rd_gnt;
      addrb_q    <= addrb;
    end
  end

  assign bus.wr_gnt   = wr_gnt;
  assign bus.rd_gnt   = rd_gnt;
  // Masked during reset so a read granted just before reset never returns.
  assign bus.rd_valid = rst ? 2'b00 : rd_valid_q;
  assign bus.rd_data  = bus.doutb;
  assign bus.wea      = wea;
  assign bus.addra    = addra;
  assign bus.dina     = dina;
  assign bus.addrb    = addrb;

endmodule

// File: tb/tb_cache_arbiter.sv
// Directed bench for cache_arbiter with a behavioural read-first dual-port cache model.
module tb_cache_arbiter;
  localparam int unsigned DW = 32;
  localparam int unsigned AW = 10;

  logic clk;
  logic rst;
  int   n_tests;
  int   n_fail;

  cache_arbiter_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

  cache_arbiter #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  // Read-first cache: doutb returns the pre-write contents, one cycle after addrb.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bus.wea) mem[bus.addra] <= bus.dina;
    bus.doutb <= mem[bus.addrb];
  end

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_inputs();
    bus.wr_req   = 2'b00;
    bus.wr_addr0 = '0;
    bus.wr_addr1 = '0;
    bus.wr_data0 = '0;
    bus.wr_data1 = '0;
    bus.rd_req   = 2'b00;
    bus.rd_addr0 = '0;
    bus.rd_addr1 = '0;
  endtask

  // Step to just after the next rising edge; inputs are driven there and outputs
  // are sampled 2 time units later, well clear of both edges.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle(input string tag);
    check_eq({tag, "_wr_gnt"}, 64'(bus.wr_gnt), 64'd0);
    check_eq({tag, "_rd_gnt"}, 64'(bus.rd_gnt), 64'd0);
    check_eq({tag, "_rd_valid"}, 64'(bus.rd_valid), 64'd0);
    check_eq({tag, "_wea"}, 64'(bus.wea), 64'd0);
    check_eq({tag, "_addra"}, 64'(bus.addra), 64'd0);
    check_eq({tag, "_dina"}, 64'(bus.dina), 64'd0);
    check_eq({tag, "_addrb"}, 64'(bus.addrb), 64'd0);
  endtask

  logic [DW-1:0] d0 [4];
  logic [DW-1:0] d1 [4];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    clk     = 1'b0;
    rst     = 1'b1;
    bus.doutb = '0;
    clear_inputs();
    // Requests during reset must not leak through to grants or the cache.
    bus.wr_req   = 2'b11;
    bus.rd_req   = 2'b11;
    bus.wr_addr0 = 10'd3;
    bus.wr_data0 = 32'h55;
    bus.rd_addr0 = 10'd4;

    repeat (2) begin
      cyc();
      #2;
      check_idle("reset");
    end

    cyc();
    rst = 1'b0;
    clear_inputs();
    #2;
    check_idle("idle0");
    cyc();
    #2;
    check_idle("idle1");

    // Single writer then reader.
    cyc();
    clear_inputs();
    bus.wr_req   = 2'b01;
    bus.wr_addr0 = 10'd5;
    bus.wr_data0 = 32'hDEADBEEF;
    #2;
    check_eq("w1_gnt", 64'(bus.wr_gnt), 64'b01);
    check_eq("w1_wea", 64'(bus.wea), 64'd1);
    check_eq("w1_addra", 64'(bus.addra), 64'd5);
    check_eq("w1_dina", 64'(bus.dina), 64'hDEADBEEF);
    cyc();
    clear_inputs();
    cyc();
    bus.rd_req   = 2'b10;
    bus.rd_addr1 = 10'd5;
    #2;
    check_eq("r1_gnt", 64'(bus.rd_gnt), 64'b10);
    check_eq("r1_addrb", 64'(bus.addrb), 64'd5);
    cyc();
    clear_inputs();
    #2;
    check_eq("r1_valid", 64'(bus.rd_valid), 64'b10);
    check_eq("r1_data", 64'(bus.rd_data), 64'hDEADBEEF);
    check_eq("r1_gnt_off", 64'(bus.rd_gnt), 64'd0);

    // Preload address 7 with 0x22 through requester 1 (also returns wr_ptr to 0).
    cyc();
    bus.wr_req   = 2'b10;
    bus.wr_addr1 = 10'd7;
    bus.wr_data1 = 32'h22;
    #2;
    check_eq("pre7_gnt", 64'(bus.wr_gnt), 64'b10);

    // Round-robin write: each requester advances its data after its own grant.
    d0 = '{32'h100, 32'h101, 32'h101, 32'h102};
    d1 = '{32'h200, 32'h200, 32'h201, 32'h201};
    for (int k = 0; k < 4; k++) begin
      cyc();
      bus.wr_req   = 2'b11;
      bus.wr_addr0 = 10'd1;
      bus.wr_addr1 = 10'd2;
      bus.wr_data0 = d0[k];
      bus.wr_data1 = d1[k];
      #2;
      check_eq($sformatf("rr_gnt%0d", k), 64'(bus.wr_gnt), (k % 2 == 0) ? 64'b01 : 64'b10);
      check_eq($sformatf("rr_dina%0d", k), 64'(bus.dina), (k % 2 == 0) ? 64'(d0[k]) : 64'(d1[k]));
    end

    // Read back addresses 1 and 2 with both readers contending.
    cyc();
    clear_inputs();
    bus.rd_req   = 2'b11;
    bus.rd_addr0 = 10'd1;
    bus.rd_addr1 = 10'd2;
    #2;
    check_eq("rb_gnt0", 64'(bus.rd_gnt), 64'b01);
    cyc();
    bus.rd_req = 2'b10;
    #2;
    check_eq("rb_gnt1", 64'(bus.rd_gnt), 64'b10);
    check_eq("rb_valid0", 64'(bus.rd_valid), 64'b01);
    check_eq("rb_data0", 64'(bus.rd_data), 64'h101);
    cyc();
    clear_inputs();
    #2;
    check_eq("rb_valid1", 64'(bus.rd_valid), 64'b10);
    check_eq("rb_data1", 64'(bus.rd_data), 64'h201);

    // Read-write hazard on address 7 (old 0x22, new 0x11).
    cyc();
    bus.wr_req   = 2'b01;
    bus.wr_addr0 = 10'd7;
    bus.wr_data0 = 32'h11;
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 10'd7;
    #2;
    check_eq("hz_wea", 64'(bus.wea), 64'd1);
    check_eq("hz_rd_gnt_stall", 64'(bus.rd_gnt), 64'b00);
    check_eq("hz_addrb", 64'(bus.addrb), 64'd7);
    cyc();
    clear_inputs();
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 10'd7;
    #2;
    check_eq("hz_rd_gnt_retry", 64'(bus.rd_gnt), 64'b01);
    check_eq("hz_valid_none", 64'(bus.rd_valid), 64'b00);
    cyc();
    clear_inputs();
    #2;
    check_eq("hz_valid", 64'(bus.rd_valid), 64'b01);
    check_eq("hz_data", 64'(bus.rd_data), 64'h11);

    // Preload addresses 8..15 with 100..107.
    for (int k = 0; k < 8; k++) begin
      cyc();
      clear_inputs();
      bus.wr_req   = 2'b01;
      bus.wr_addr0 = AW'(8 + k);
      bus.wr_data0 = DW'(100 + k);
      #2;
      check_eq($sformatf("pl_gnt%0d", k), 64'(bus.wr_gnt), 64'b01);
    end

    // Concurrent non-colliding traffic: one write and one read every cycle.
    for (int k = 0; k < 9; k++) begin
      cyc();
      clear_inputs();
      if (k < 8) begin
        bus.wr_req   = 2'b10;
        bus.wr_addr1 = AW'(k);
        bus.wr_data1 = DW'(32'h300 + k);
        bus.rd_req   = 2'b01;
        bus.rd_addr0 = AW'(8 + k);
      end
      #2;
      if (k < 8) begin
        check_eq($sformatf("cc_wgnt%0d", k), 64'(bus.wr_gnt), 64'b10);
        check_eq($sformatf("cc_rgnt%0d", k), 64'(bus.rd_gnt), 64'b01);
      end else begin
        check_eq("cc_addrb_hold", 64'(bus.addrb), 64'd15);
      end
      if (k > 0) begin
        check_eq($sformatf("cc_valid%0d", k), 64'(bus.rd_valid), 64'b01);
        check_eq($sformatf("cc_data%0d", k), 64'(bus.rd_data), 64'(100 + k - 1));
      end
    end

    // Reset mid-read: the outstanding read must not return, and rd_ptr restarts at 0.
    cyc();
    clear_inputs();
    bus.rd_req   = 2'b01;
    bus.rd_addr0 = 10'd8;
    #2;
    check_eq("rst_rd_gnt", 64'(bus.rd_gnt), 64'b01);
    cyc();
    rst          = 1'b1;
    bus.rd_req   = 2'b11;
    bus.rd_addr1 = 10'd9;
    #2;
    check_eq("rst_rd_valid", 64'(bus.rd_valid), 64'b00);
    check_eq("rst_rd_gnt_off", 64'(bus.rd_gnt), 64'b00);
    cyc();
    rst = 1'b0;
    #2;
    check_eq("rst_rd_valid_after", 64'(bus.rd_valid), 64'b00);
    check_eq("rst_ptr_gnt", 64'(bus.rd_gnt), 64'b01);
    cyc();
    clear_inputs();
    #2;
    check_eq("rst_post_valid", 64'(bus.rd_valid), 64'b01);
    check_eq("rst_post_data", 64'(bus.rd_data), 64'd100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
